ama_riscv_load_scoreboard: RTL
==============================

// Module: ama_riscv_load_scoreboard
// PURPOSE
//  Producer-side companion to ID-stage operand forwarding. EX-stage ALU results forward with no stall;
//  load results do not exist until the data memory responds, so they cannot forward that way.
//  This block tracks outstanding loads in an in-order tag FIFO plus a per-register pending mask.
//  It raises stall_id for RAW/WAW hazards on load destinations and when the FIFO is full.
//  It tags each memory response with its rd for the write-back mux. Sits between ID control and MEM/WB.
// PARAMETERS
//  RF_AW     5  register index width (32 GPRs, x0 hard-wired zero)
//  LD_DEPTH  4  max outstanding loads; power of 2, >=2
// PORTS
//  clk           in   1        core clock, all state on rising edge
//  rst_n         in   1        asynchronous active-low reset
//  issue_valid   in   1        instruction in ID advances to EX this cycle (pre-stall)
//  issue_we      in   1        issuing instruction writes rd
//  issue_is_load in   1        issuing instruction is a load
//  issue_rd      in   RF_AW    destination of issuing instruction
//  rs1_id        in   RF_AW    source 1 of instruction in ID
//  rs2_id        in   RF_AW    source 2 of instruction in ID
//  rs1_used      in   1        rs1 is read by the instruction in ID
//  rs2_used      in   1        rs2 is read by the instruction in ID
//  flush         in   1        kill the ID instruction this cycle (branch/jump redirect)
//  ld_rsp_valid  in   1        data memory returns one load result (in order, no backpressure)
//  stall_id      out  1        hold PC and IF/ID, inject bubble into EX
//  ld_wb_valid   out  1        load result being written back this cycle
//  ld_wb_rd      out  RF_AW    rd for ld_wb_valid (head of tag FIFO)
//  ld_pending    out  2^RF_AW  registered pending-load mask, bit0 always 0
//  ld_full       out  1        FIFO holds LD_DEPTH entries
//  ld_err        out  1        sticky: response arrived with FIFO empty
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - wr/rd pointers, count, ld_pending, ld_err all cleared.
//   - stall_id=0, ld_full=0, ld_wb_valid=0 (ld_wb_valid is combinational from ld_rsp_valid && count!=0).
//   - Reset mid-operation drops all outstanding tags; no late responses are expected after reset.
//  Pop (same cycle as ld_rsp_valid when count!=0):
//   - ld_wb_valid=1, ld_wb_rd=fifo[rd_ptr], clr_mask = onehot(ld_wb_rd).
//   - Next edge: rd_ptr++, ld_pending &= ~clr_mask.
//   - ld_rsp_valid with count==0: no pop, ld_wb_valid=0, ld_err<=1 (cleared only by reset).
//  Effective mask (combinational): eff = ld_pending & ~clr_mask.
//   - A register whose load completes this cycle is already free; the WB bypass supplies its data.
//  stall_id (combinational) = issue_valid && !flush && (h1 | h2 | hw | hf):
//   - h1 = rs1_used && rs1_id!=0 && eff[rs1_id]   (RAW on load)
//   - h2 = rs2_used && rs2_id!=0 && eff[rs2_id]   (RAW on load)
//   - hw = issue_we && issue_rd!=0 && eff[issue_rd]   (WAW; keeps one pending load per rd)
//   - hf = issue_is_load && issue_we && (count - pop == LD_DEPTH)   (full after this cycle's pop)
//  Push: fire = issue_valid && !flush && !stall_id && issue_is_load && issue_we && issue_rd!=0.
//   - Next edge: fifo[wr_ptr]<=issue_rd, wr_ptr++, ld_pending[issue_rd]<=1.
//   - A load to x0 is not tracked; memory must not return a response for it (ID marks it non-load).
//  Simultaneous push+pop: count unchanged.
//   - Set and clear never hit the same rd: WAW is checked against eff, which already has the pop cleared.
//  Pointers are log2(LD_DEPTH) bits and wrap naturally. count is log2(LD_DEPTH)+1 bits, 0..LD_DEPTH.
//  ld_full = (count==LD_DEPTH).
//  flush: suppresses push and stall for the killed instruction only.
//   - Loads already pushed stay tracked; they were issued to memory and must retire.
//  Latency:
//   - stall is zero-cycle (combinational).
//   - A load followed by a dependent instruction stalls until the cycle its response arrives.
//   - The dependent instruction issues in that same cycle.
// STRUCTURE
//  Shared defines:
//   - RF_X0_ZERO
//   - RF_AW default
//   - LD_DEPTH default
//  Sub-module ama_riscv_tag_fifo: sync FIFO (push/pop/head/count/full), LD_DEPTH x RF_AW.
//   - Top level holds the pending mask, hazard compare and error flag.
// TESTING
//  T1 reset:
//   - Assert rst_n=0 mid-traffic, asynchronously.
//   - All outputs 0 immediately; ld_pending==0 after release.
//  T2 load-use RAW:
//   - Issue load x5; next cycle ID reads rs1=x5 -> stall_id=1 each cycle.
//   - 3 cycles later ld_rsp_valid=1 -> ld_wb_rd=5, stall_id=0 that cycle, ld_pending[5]=0 next.
//  T3 x0 and unused sources:
//   - Pending x7; ID rs1=x0, rs2=x7 with rs2_used=0 -> stall_id=0.
//   - Load to x0 issued -> no push, count unchanged.
//  T4 full FIFO:
//   - Issue 4 loads x1..x4, no responses -> ld_full=1; 5th load (x9) stalls.
//   - Response in the same cycle -> pops x1, x9 pushes, count stays 4.
//  T5 WAW and order:
//   - Load x3 pending; issue ALU writing x3 -> stall until the x3 response.
//   - Responses return rd in push order 3,6,8.
//  T6 error and flush:
//   - ld_rsp_valid with empty FIFO -> ld_err=1 sticky, no wb.
//   - flush with a hazardous ID instruction -> stall_id=0, no push.

Source files
------------

// File: rtl/ama_riscv_load_scoreboard_pkg.sv
// Load scoreboard shared definitions.
// Default geometry and register-file conventions.
package ama_riscv_load_scoreboard_pkg;

  localparam int RF_AW_DEF    = 5;
  localparam int LD_DEPTH_DEF = 4;
  localparam bit RF_X0_ZERO   = 1'b1;

endpackage

// File: rtl/ama_riscv_tag_fifo.sv
// In-order tag FIFO holding destination registers
// of loads still waiting on data memory.
module ama_riscv_tag_fifo #(
  parameter int DW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/ama_riscv_load_scoreboard.sv
// Tracks outstanding loads and stalls ID on
// load RAW/WAW hazards or a full tag FIFO.
import ama_riscv_load_scoreboard_pkg::*;

module ama_riscv_load_scoreboard #(
  parameter int RF_AW    = RF_AW_DEF,
  parameter int LD_DEPTH = LD_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic                  issue_is_load,
  input  logic [RF_AW-1:0]      issue_rd,
  input  logic [RF_AW-1:0]      rs1_id,
  input  logic [RF_AW-1:0]      rs2_id,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  flush,
  input  logic                  ld_rsp_valid,
  output logic                  stall_id,
  output logic                  ld_wb_valid,
  output logic [RF_AW-1:0]      ld_wb_rd,
  output logic [(1<<RF_AW)-1:0] ld_pending,
  output logic                  ld_full,
  output logic                  ld_err
);

  localparam int NR = 1 << RF_AW;
  localparam int CW = $clog2(LD_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LD_DEPTH);
  localparam logic [NR-1:0] ONE = {{(NR-1){1'b0}}, 1'b1};

  logic [CW-1:0] count;
  logic          pop;
  logic          fire;
  logic          h1, h2, hw, hf;
  logic          rs1_nz, rs2_nz, rd_nz;
  logic [NR-1:0] clr_mask;
  logic [NR-1:0] set_mask;
  logic [NR-1:0] eff;

  assign rs1_nz = !RF_X0_ZERO || (rs1_id != '0);
  assign rs2_nz = !RF_X0_ZERO || (rs2_id != '0);
  assign rd_nz  = !RF_X0_ZERO || (issue_rd != '0);

  assign pop         = ld_rsp_valid && (count != '0);
  assign ld_wb_valid = pop;

  // A load completing now is already free: WB bypass feeds it.
  always_comb begin
    clr_mask = '0;
    if (pop) clr_mask = ONE << ld_wb_rd;
    eff = ld_pending & ~clr_mask;
  end

  always_comb begin
    h1 = rs1_used && rs1_nz && eff[rs1_id];
    h2 = rs2_used && rs2_nz && eff[rs2_id];
    hw = issue_we && rd_nz && eff[issue_rd];
    hf = issue_is_load && issue_we &&
         (count == FULL_CNT) && !pop;
    stall_id = issue_valid && !flush &&
               (h1 || h2 || hw || hf);
  end

  always_comb begin
    fire = issue_valid && !flush && !stall_id &&
           issue_is_load && issue_we && rd_nz;
    set_mask = '0;
    if (fire) set_mask = ONE << issue_rd;
  end

  ama_riscv_tag_fifo #(
    .DW    (RF_AW),
    .DEPTH (LD_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fire),
    .push_data (issue_rd),
    .pop       (pop),
    .head      (ld_wb_rd),
    .count     (count),
    .full      (ld_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_pending <= '0;
      ld_err     <= 1'b0;
    end else begin
      ld_pending <= (ld_pending & ~clr_mask) | set_mask;
      if (ld_rsp_valid && (count == '0)) ld_err <= 1'b1;
    end
  end

endmodule
